apb_mailbox_slave: RTL

APB completer that exposes a FIFO mailbox to the masters through the existing APB interconnect.
- One master writes words into the mailbox; any master reads them back out in order.
- Offers programmable wait states, PSLVERR on illegal accesses, and a level-threshold interrupt.
- Sits on one PSEL bit of the interconnect's slave side, alongside the memory slaves.

---
 rtl/apb_pkg.sv | 43 ++++
 rtl/mailbox_fifo.sv | 86 ++++++++
 rtl/apb_mailbox_slave.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB mailbox completer: FSM state
//               encoding, committed-operation encoding, register offsets and
//               STATUS register bit positions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // APB completer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Side effect captured at decode time and applied on the last ACCESS edge
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POP    = 3'd2,
    OP_FLUSH  = 3'd3,
    OP_THRESH = 3'd4
  } mb_op_e;

  // Register offsets relative to the base word address
  localparam logic [1:0] MB_DATA   = 2'd0;
  localparam logic [1:0] MB_STATUS = 2'd1;
  localparam logic [1:0] MB_CTRL   = 2'd2;
  localparam logic [1:0] MB_THRESH = 2'd3;

  // STATUS register layout: {.., count, full, empty}
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;

  // Wait-state counter width (covers 0..15)
  localparam int WAIT_CNT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mailbox_fifo
// Description : Single-clock circular FIFO with show-ahead head output,
//               occupancy count and one-cycle flush.
// Ports       : i_clk, i_rst_n (async, active low)
//               i_push/i_pop/i_flush  - operation strobes (flush dominates)
//               i_wdata               - data pushed on i_push
//               o_rdata               - current head entry (show-ahead)
//               o_count/o_full/o_empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module mailbox_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic                          i_flush,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == COUNT_WIDTH'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // Overflow/underflow strobes are ignored so the pointers can never skew.
  assign w_do_push = i_push && !w_full  && !i_flush;
  assign w_do_pop  = i_pop  && !w_empty && !i_flush;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
        2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/apb_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_mailbox_slave
// Description : APB completer exposing a FIFO mailbox. Registers:
//               0 DATA (write pushes, read pops), 1 STATUS (RO),
//               2 CTRL (WO, bit0 flush), 3 THRESH (RW). Programmable wait
//               states, PSLVERR on illegal accesses, level-threshold IRQ.
// Ports       : I_PCLK, I_PRESETN (async, active low)
//               I_PADDR/I_PSEL/I_PENABLE/I_PWRITE/I_PWDATA - APB request
//               O_PREADY/O_PRDATA/O_PSLVERR                 - APB response
//               O_IRQ - registered level interrupt (count >= THRESH != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mailbox_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FIFO_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASEADDRESS = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  I_PCLK,
  input  logic                  I_PRESETN,
  input  logic [ADDR_WIDTH-1:0] I_PADDR,
  input  logic                  I_PSEL,
  input  logic                  I_PENABLE,
  input  logic                  I_PWRITE,
  input  logic [DATA_WIDTH-1:0] I_PWDATA,
  output logic                  O_PREADY,
  output logic [DATA_WIDTH-1:0] O_PRDATA,
  output logic                  O_PSLVERR,
  output logic                  O_IRQ
);

  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  // FSM and captured transfer
  apb_state_e                r_state;
  logic [WAIT_CNT_WIDTH-1:0] r_wait;
  mb_op_e                    r_op;
  logic                      r_err;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [COUNT_WIDTH-1:0]    r_thresh;
  logic                      r_irq;

  // FIFO status
  logic [DATA_WIDTH-1:0]  w_fifo_rdata;
  logic [COUNT_WIDTH-1:0] w_count;
  logic                   w_full;
  logic                   w_empty;

  // Decode
  logic [ADDR_WIDTH-1:0]  w_offset;
  logic [DATA_WIDTH-1:0]  w_status;
  mb_op_e                 w_op;
  logic                   w_err;
  logic [DATA_WIDTH-1:0]  w_rdata;

  // Commit
  logic w_ready;
  logic w_commit;
  logic w_push;
  logic w_pop;
  logic w_flush;

  assign w_offset = I_PADDR - BASEADDRESS;

  always_comb begin
    w_status                                       = '0;
    w_status[STATUS_EMPTY_BIT]                     = w_empty;
    w_status[STATUS_FULL_BIT]                      = w_full;
    w_status[STATUS_COUNT_LSB +: COUNT_WIDTH]      = w_count;
  end

  // Illegal accesses keep w_err high and w_op at OP_NONE.
  always_comb begin
    w_op    = OP_NONE;
    w_err   = 1'b1;
    w_rdata = '0;
    if (w_offset < ADDR_WIDTH'(4)) begin
      case (w_offset[1:0])
        MB_DATA: begin
          if (I_PWRITE) begin
            if (!w_full) begin
              w_op  = OP_PUSH;
              w_err = 1'b0;
            end
          end else if (!w_empty) begin
            w_op    = OP_POP;
            w_err   = 1'b0;
            w_rdata = w_fifo_rdata;
          end
        end
        MB_STATUS: begin
          if (!I_PWRITE) begin
            w_err   = 1'b0;
            w_rdata = w_status;
          end
        end
        MB_CTRL: begin
          if (I_PWRITE) begin
            w_err = 1'b0;
            w_op  = I_PWDATA[0] ? OP_FLUSH : OP_NONE;
          end
        end
        MB_THRESH: begin
          w_err = 1'b0;
          if (I_PWRITE) begin
            w_op = OP_THRESH;
          end else begin
            w_rdata = DATA_WIDTH'(r_thresh);
          end
        end
        default: begin
          w_err = 1'b1;
        end
      endcase
    end
  end

  // Decode is captured on the SETUP->ACCESS edge; the single APB port means
  // FIFO occupancy cannot move while the transfer sits in ACCESS.
  always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
    if (!I_PRESETN) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_op    <= OP_NONE;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_PSEL && !I_PENABLE) begin
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= WAIT_CNT_WIDTH'(WAIT_STATES);
          r_op    <= w_op;
          r_err   <= w_err;
          r_rdata <= w_rdata;
          r_wdata <= I_PWDATA;
        end
        ST_ACCESS: begin
          if (!I_PSEL) begin
            // Master abandoned the transfer: drop it without side effect.
            r_state <= ST_IDLE;
            r_op    <= OP_NONE;
          end else if (r_wait != '0) begin
            r_wait <= r_wait - WAIT_CNT_WIDTH'(1);
          end else begin
            r_state <= (I_PSEL && !I_PENABLE) ? ST_SETUP : ST_IDLE;
            r_op    <= OP_NONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_ready  = (r_state == ST_ACCESS) && (r_wait == '0);
  assign w_commit = w_ready && I_PSEL && !r_err;
  assign w_push   = w_commit && (r_op == OP_PUSH);
  assign w_pop    = w_commit && (r_op == OP_POP);
  assign w_flush  = w_commit && (r_op == OP_FLUSH);

  always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
    if (!I_PRESETN) begin
      r_thresh <= '0;
    end else if (w_commit && (r_op == OP_THRESH)) begin
      r_thresh <= r_wdata[COUNT_WIDTH-1:0];
    end
  end

  // Registered from current count/THRESH, so it follows them by one cycle.
  always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
    if (!I_PRESETN) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_thresh != '0) && (w_count >= r_thresh);
    end
  end

  mailbox_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (I_PCLK),
    .i_rst_n (I_PRESETN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (r_wdata),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Response fields read as zero outside the PREADY cycle.
  assign O_PREADY  = w_ready;
  assign O_PRDATA  = w_ready ? r_rdata : '0;
  assign O_PSLVERR = w_ready && r_err;
  assign O_IRQ     = r_irq;

endmodule
`default_nettype wire
